// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: builds the per-stage
// stall vector, sequences multi-cycle EX ops, counts stall cycles and watches MEM.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   stallreq_if/id/ex/mem  per-stage stall requests
//   mc_start, mc_len       start of a multi-cycle EX op and its latency
//   flush_req              exception flush from MEM
//   perf_clr               synchronous clear of stall_cycles
//   stall[5:0]             {wb, mem, ex, id, if, pc} hold controls (combinational)
//   flush                  flush_req passed through
//   mc_busy, mc_done       multi-cycle op in flight / result-valid pulse
//   stall_cycles           saturating count of cycles with stall[0] set
//   bus_timeout            one-cycle pulse when MEM has stalled MEM_TIMEOUT cycles
module pipe_stall_ctrl #(
    parameter int MC_W        = 6,
    parameter int PERF_W      = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              mc_start,
    input  logic [MC_W-1:0]   mc_len,
    input  logic              flush_req,
    input  logic              perf_clr,
    output logic [5:0]        stall,
    output logic              flush,
    output logic              mc_busy,
    output logic              mc_done,
    output logic [PERF_W-1:0] stall_cycles,
    output logic              bus_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] WD_MAX = 16'(MEM_TIMEOUT);

    state_t            state_q, state_d;
    logic [MC_W-1:0]   count_q, count_d;
    logic              mc_done_q, mc_done_d;
    logic [PERF_W-1:0] perf_q, perf_d;
    logic [15:0]       wd_q, wd_d;
    logic              bt_q, bt_d;
    logic              ex_mc;

    // EX is held from the cycle the op is issued until the countdown ends;
    // the DONE cycle releases EX so the result can move on.
    always_comb begin
        ex_mc = ((state_q == IDLE) && mc_start) || (state_q == BUSY);
    end

    always_comb begin
        stall = 6'b000000;
        if (flush_req) begin
            stall = 6'b000000;
        end else if (stallreq_mem) begin
            stall = 6'b011111;
        end else if (stallreq_ex || ex_mc) begin
            stall = 6'b001111;
        end else if (stallreq_id) begin
            stall = 6'b000111;
        end else if (stallreq_if) begin
            stall = 6'b000011;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (flush_req) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mc_start) begin
                        state_d = BUSY;
                        // A zero latency is treated as one cycle.
                        count_d = (mc_len == '0) ? MC_W'(1) : mc_len;
                    end
                end
                BUSY: begin
                    count_d = count_q - MC_W'(1);
                    if (count_q == MC_W'(1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
        mc_done_d = (state_d == DONE);
    end

    always_comb begin
        perf_d = perf_q;
        if (perf_clr) begin
            perf_d = '0;
        end else if (stall[0] && (perf_q != '1)) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    // The watchdog only reports; releasing the stall is left to the
    // exception logic via flush_req.
    always_comb begin
        wd_d = '0;
        bt_d = 1'b0;
        if (stallreq_mem && !flush_req) begin
            if ((wd_q + 16'd1) == WD_MAX) begin
                wd_d = '0;
                bt_d = 1'b1;
            end else begin
                wd_d = wd_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            mc_done_q <= 1'b0;
            perf_q    <= '0;
            wd_q      <= '0;
            bt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            mc_done_q <= mc_done_d;
            perf_q    <= perf_d;
            wd_q      <= wd_d;
            bt_q      <= bt_d;
        end
    end

    assign flush        = flush_req;
    assign mc_busy      = (state_q != IDLE);
    assign mc_done      = mc_done_q;
    assign stall_cycles = perf_q;
    assign bus_timeout  = bt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: expected per-cycle outputs are queued
// when a step is driven and popped when the outputs are sampled.
module tb_pipe_stall_ctrl;

    localparam int MC_W   = 6;
    localparam int PERF_W = 4;

    logic              clk;
    logic              reset_n;
    logic              stallreq_if;
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              stallreq_mem;
    logic              mc_start;
    logic [MC_W-1:0]   mc_len;
    logic              flush_req;
    logic              perf_clr;
    logic [5:0]        stall;
    logic              flush;
    logic              mc_busy;
    logic              mc_done;
    logic [PERF_W-1:0] stall_cycles;
    logic              bus_timeout;

    pipe_stall_ctrl #(
        .MC_W(MC_W),
        .PERF_W(PERF_W),
        .MEM_TIMEOUT(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .stallreq_if(stallreq_if),
        .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .mc_start(mc_start),
        .mc_len(mc_len),
        .flush_req(flush_req),
        .perf_clr(perf_clr),
        .stall(stall),
        .flush(flush),
        .mc_busy(mc_busy),
        .mc_done(mc_done),
        .stall_cycles(stall_cycles),
        .bus_timeout(bus_timeout)
    );

    typedef struct {
        string      tag;
        logic [5:0] stall;
        logic       flush;
        logic       busy;
        logic       done;
        logic       bt;
    } exp_t;

    exp_t              sb[$];
    int                total = 0;
    int                bad = 0;
    logic [PERF_W-1:0] perf_exp = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // req = {if, id, ex, mem, flush}
    task automatic step(input string tag, input logic [4:0] req,
                        input logic st, input logic [MC_W-1:0] len,
                        input logic clr, input logic [5:0] e_stall,
                        input logic e_busy, input logic e_done,
                        input logic e_bt);
        exp_t e;
        exp_t g;
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, flush_req} = req;
        mc_start = st;
        mc_len   = len;
        perf_clr = clr;
        e.tag   = tag;
        e.stall = e_stall;
        e.flush = req[0];
        e.busy  = e_busy;
        e.done  = e_done;
        e.bt    = e_bt;
        sb.push_back(e);
        #2;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            chk({g.tag, "_stall"}, 32'(stall), 32'(g.stall));
            chk({g.tag, "_flush"}, 32'(flush), 32'(g.flush));
            chk({g.tag, "_busy"}, 32'(mc_busy), 32'(g.busy));
            chk({g.tag, "_done"}, 32'(mc_done), 32'(g.done));
            chk({g.tag, "_bt"}, 32'(bus_timeout), 32'(g.bt));
            chk({g.tag, "_perf"}, 32'(stall_cycles), 32'(perf_exp));
            if (clr) perf_exp = '0;
            else if (g.stall[0] && perf_exp != '1) perf_exp = perf_exp + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n      = 1'b0;
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        mc_start     = 1'b0;
        mc_len       = '0;
        flush_req    = 1'b0;
        perf_clr     = 1'b0;
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(mc_busy), 32'd0);
        chk("rst_done", 32'(mc_done), 32'd0);
        chk("rst_perf", 32'(stall_cycles), 32'd0);
        chk("rst_bt", 32'(bus_timeout), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // priority
        step("pri_ifid", 5'b11000, 0, 0, 0, 6'b000111, 0, 0, 0);
        step("pri_ex", 5'b11100, 0, 0, 0, 6'b001111, 0, 0, 0);
        step("pri_mem", 5'b11110, 0, 0, 0, 6'b011111, 0, 0, 0);
        step("pri_flush", 5'b11111, 0, 0, 0, 6'b000000, 0, 0, 0);
        step("pri_if", 5'b10000, 0, 0, 0, 6'b000011, 0, 0, 0);
        step("idle", 5'b00000, 0, 0, 0, 6'b000000, 0, 0, 0);

        // 4-cycle op
        step("mc4_t0", 5'b00000, 1, 4, 0, 6'b001111, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step("mc4_busy", 5'b00000, 0, 0, 0, 6'b001111, 1, 0, 0);
        step("mc4_done", 5'b00000, 0, 0, 0, 6'b000000, 1, 1, 0);
        step("mc4_idle", 5'b00000, 0, 0, 0, 6'b000000, 0, 0, 0);

        // zero latency, restarts ignored in BUSY/DONE
        step("mc0_t0", 5'b00000, 1, 0, 0, 6'b001111, 0, 0, 0);
        step("mc0_busy_ign", 5'b00000, 1, 9, 0, 6'b001111, 1, 0, 0);
        step("mc0_done_ign", 5'b00000, 1, 9, 0, 6'b000000, 1, 1, 0);
        step("mc0_idle", 5'b00000, 0, 0, 0, 6'b000000, 0, 0, 0);

        // flush mid-op
        step("fl_t0", 5'b00000, 1, 4, 0, 6'b001111, 0, 0, 0);
        step("fl_t1", 5'b00000, 0, 0, 0, 6'b001111, 1, 0, 0);
        step("fl_t2", 5'b00001, 0, 0, 0, 6'b000000, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            step("fl_after", 5'b00000, 0, 0, 0, 6'b000000, 0, 0, 0);
        step("fl_start", 5'b00001, 1, 3, 0, 6'b000000, 0, 0, 0);
        step("fl_start_n", 5'b00000, 0, 0, 0, 6'b000000, 0, 0, 0);

        // MEM stall over an op, done still pulses; watchdog fires too
        step("mm_t0", 5'b00010, 1, 2, 0, 6'b011111, 0, 0, 0);
        step("mm_t1", 5'b00010, 0, 0, 0, 6'b011111, 1, 0, 0);
        step("mm_t2", 5'b00010, 0, 0, 0, 6'b011111, 1, 0, 0);
        step("mm_done", 5'b00010, 0, 0, 0, 6'b011111, 1, 1, 1);
        step("mm_idle", 5'b00000, 0, 0, 0, 6'b000000, 0, 0, 0);

        // watchdog with timeout 3 over 7 MEM stall cycles
        step("wd_clr", 5'b00000, 0, 0, 1, 6'b000000, 0, 0, 0);
        for (int k = 1; k <= 7; k++)
            step("wd", 5'b00010, 0, 0, 0, 6'b011111, 0, 0, (k == 4) || (k == 7));
        chk("perf7", 32'(stall_cycles), 32'd7);
        step("wd_end", 5'b00000, 0, 0, 0, 6'b000000, 0, 0, 0);
        step("perf_clr", 5'b00000, 0, 0, 1, 6'b000000, 0, 0, 0);
        chk("perf_zero", 32'(stall_cycles), 32'd0);

        // saturation and clear priority
        for (int i = 0; i < 18; i++)
            step("sat", 5'b01000, 0, 0, 0, 6'b000111, 0, 0, 0);
        chk("perf_sat", 32'(stall_cycles), 32'd15);
        step("clr_win", 5'b01000, 0, 0, 1, 6'b000111, 0, 0, 0);
        step("after_clr", 5'b00000, 0, 0, 0, 6'b000000, 0, 0, 0);

        // async reset mid-op
        step("rs_t0", 5'b00010, 1, 8, 0, 6'b011111, 0, 0, 0);
        step("rs_t1", 5'b00010, 0, 0, 0, 6'b011111, 1, 0, 0);
        chk("rs_pre_busy", 32'(mc_busy), 32'd1);
        stallreq_mem = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rs_busy", 32'(mc_busy), 32'd0);
        chk("rs_perf", 32'(stall_cycles), 32'd0);
        chk("rs_done", 32'(mc_done), 32'd0);
        chk("rs_stall", 32'(stall), 32'(6'b011111));
        stallreq_mem = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        perf_exp = '0;
        step("rs_new", 5'b00000, 1, 1, 0, 6'b001111, 0, 0, 0);
        step("rs_busy1", 5'b00000, 0, 0, 0, 6'b001111, 1, 0, 0);
        step("rs_done1", 5'b00000, 0, 0, 0, 6'b000000, 1, 1, 0);
        step("rs_idle", 5'b00000, 0, 0, 0, 6'b000000, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
